// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor controller.
package serial_add_pkg;

  localparam int SA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

endpackage

// File: rtl/serial_add_ctrl_fulladder.sv
// Single 1-bit full-adder cell, time-shared by the serial controller.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic c1
);

  assign s  = a ^ b ^ c;
  assign c1 = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell walked LSB-first
// across WIDTH bits, with valid/ready handshakes on operands and result.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_C = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MSB_C  = CW'(WIDTH - 2);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  sa_state_t        state_r;
  sa_state_t        state_n_s;
  logic             accept_s;
  logic             step_s;
  logic             last_s;

  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-2:0] shift_r;
  logic [WIDTH-1:0] shift_n_s;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             carry_msb_r;
  logic [CW-1:0]    count_r;
  logic             cout_r;
  logic             ovf_r;
  logic             cell_sum_s;
  logic             cell_carry_s;

  fulladder u_cell (
    .a  (op_a_r[0]),
    .b  (op_b_r[0]),
    .c  (carry_r),
    .s  (cell_sum_s),
    .c1 (cell_carry_s)
  );

  // Sum bit enters at the top; the full word is complete on the last step.
  assign shift_n_s = {cell_sum_s, shift_r};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next-state decode and datapath enables.
  always_comb begin
    state_n_s = state_r;
    accept_s  = 1'b0;
    step_s    = 1'b0;
    last_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s  = 1'b1;
          state_n_s = RUN;
        end else begin
          state_n_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (count_r == LAST_C) begin
          last_s    = 1'b1;
          state_n_s = DONE;
        end else begin
          state_n_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = DONE;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // Operand latch, serial shift, and result capture on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_r      <= '0;
      op_b_r      <= '0;
      shift_r     <= '0;
      sum_r       <= '0;
      carry_r     <= 1'b0;
      carry_msb_r <= 1'b0;
      count_r     <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (accept_s) begin
      op_a_r  <= a;
      op_b_r  <= sub ? ~b : b;
      carry_r <= sub | cin;
      count_r <= '0;
    end else if (step_s) begin
      op_a_r  <= {1'b0, op_a_r[WIDTH-1:1]};
      op_b_r  <= {1'b0, op_b_r[WIDTH-1:1]};
      shift_r <= shift_n_s[WIDTH-1:1];
      carry_r <= cell_carry_s;
      count_r <= count_r + ONE_C;
      if (count_r == MSB_C) begin
        carry_msb_r <= cell_carry_s;
      end
      // Result registers only change here, so they stay put through DONE and IDLE.
      if (last_s) begin
        sum_r  <= shift_n_s;
        cout_r <= cell_carry_s;
        ovf_r  <= carry_msb_r ^ cell_carry_s;
      end
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: scoreboard of expected results,
// one task per scenario.
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  // Reference: plain wide arithmetic, overflow from operand/result signs.
  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic s);
    logic [W:0]   full;
    logic [W-1:0] yy;
    logic         c0;
    exp_t         e;
    yy     = s ? ~y : y;
    c0     = s ? 1'b1 : ci;
    full   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c0};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (x[W-1] == yy[W-1]) && (e.sum[W-1] != x[W-1]);
    return e;
  endfunction

  // Present one operand pair at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic s, input bit push);
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    if (push) sb_q.push_back(model(x, y, ci, s));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit timed_out);
    lat = 0;
    timed_out = 1'b0;
    while (!out_valid) begin
      if (lat >= 40) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
    end
    checks++;
    if ({sum, cout, ovf} !== {W+2{1'b0}}) begin
      errors++;
      $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b want 0", sum, cout, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL idle_hold: got rdy/busy=%b want 10", {in_ready, busy});
    end
  endtask

  task automatic test_add_sub;
    logic [W-1:0] va [5] = '{8'h3C, 8'hFF, 8'hFF, 8'h10, 8'h80};
    logic [W-1:0] vb [5] = '{8'h55, 8'h01, 8'h01, 8'h20, 8'h01};
    logic         vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic         vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W+1:0] want [5] = '{{8'h91, 1'b0, 1'b1}, {8'h00, 1'b1, 1'b0},
                               {8'h01, 1'b1, 1'b0}, {8'hF0, 1'b0, 1'b0},
                               {8'h7F, 1'b1, 1'b1}};
    int   lat;
    bit   to;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      send(va[i], vb[i], vc[i], vs[i], 1'b1);
      wait_out(lat, to);
      checks++;
      if (to || lat != W) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d (timeout=%0b) want %0d", i, lat, to, W);
      end
      e = sb_q.pop_front();
      checks++;
      if ({e.sum, e.cout, e.ovf} !== want[i]) begin
        errors++;
        $display("FAIL table[%0d]: model %h want %h", i, {e.sum, e.cout, e.ovf}, want[i]);
      end
      checks++;
      if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
        errors++;
        $display("FAIL result[%0d]: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 i, sum, cout, ovf, e.sum, e.cout, e.ovf);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
        errors++;
        $display("FAIL release[%0d]: got rdy/vld=%b want 10", i, {in_ready, out_valid});
      end
    end
  endtask

  task automatic test_backpressure;
    int   lat;
    bit   to;
    exp_t e;
    out_ready = 1'b0;
    send(8'h05, 8'h03, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL run_ready[%0d]: got %b want 0", i, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_out(lat, to);
    e = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      a = 8'h77; in_valid = 1'b1;
      checks++;
      if (to || {out_valid, in_ready, sum, cout, ovf} !== {2'b10, e.sum, e.cout, e.ovf}) begin
        errors++;
        $display("FAIL hold[%0d]: got vld=%b rdy=%b sum=%h cout=%b ovf=%b want vld=1 rdy=0 sum=%h cout=%b ovf=%b",
                 i, out_valid, in_ready, sum, cout, ovf, e.sum, e.cout, e.ovf);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid, sum} !== {2'b10, 8'h08}) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b vld=%b sum=%h want rdy=1 vld=0 sum=08",
               in_ready, out_valid, sum);
    end
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, busy} !== 2'b00) begin
        errors++;
        $display("FAIL stray_req[%0d]: got vld/busy=%b want 00", i, {out_valid, busy});
      end
    end
  endtask

  task automatic test_mid_run_reset;
    int   lat;
    bit   to;
    exp_t e;
    send(8'hAA, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, sum, cout, ovf} !== {3'b100, {W+2{1'b0}}}) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b vld=%b busy=%b sum=%h cout=%b ovf=%b want rdy=1 others 0",
               in_ready, out_valid, busy, sum, cout, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    wait_out(lat, to);
    e = sb_q.pop_front();
    checks++;
    if (to || {sum, cout, ovf} !== {e.sum, e.cout, e.ovf} || e.sum !== 8'h02) begin
      errors++;
      $display("FAIL post_reset: got sum=%h cout=%b ovf=%b (timeout=%0b) want sum=02 cout=0 ovf=0",
               sum, cout, ovf, to);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int   idx = 0;
    int   got = 0;
    int   last_acc = 0;
    exp_t e;
    out_ready = 1'b1;
    for (int n = 0; n < 200 && got < 4; n++) begin
      if (out_valid) begin
        e = sb_q.pop_front();
        got++;
        checks++;
        if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
          errors++;
          $display("FAIL b2b[%0d]: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                   got, sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
      end
      if (in_ready && idx < 4) begin
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        sb_q.push_back(model(a, b, cin, sub));
        if (idx > 0) begin
          checks++;
          if (cyc - last_acc != W + 2) begin
            errors++;
            $display("FAIL spacing[%0d]: got %0d want %0d", idx, cyc - last_acc, W + 2);
          end
        end
        last_acc = cyc;
        idx++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d results want 4", got);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_backpressure();
    test_mid_run_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
